// File: rtl/time_pkg.sv
// time_pkg: shared types and calendar helpers for the time-setting controller.
//   state_t       : edit FSM state; the encoding doubles as the display field index
//   FLD_*         : field index constants (0 = not editing)
//   MON..SUN      : weekday encodings, 1 = Monday .. 7 = Sunday
//   is_leap       : Gregorian leap-year test
//   month_len     : days in a month for a given year
//   zeller_to_iso : maps a Zeller weekday (0 = Saturday) onto MON..SUN
package time_pkg;

  localparam logic [2:0] FLD_RUN   = 3'd0;
  localparam logic [2:0] FLD_YEAR  = 3'd1;
  localparam logic [2:0] FLD_MONTH = 3'd2;
  localparam logic [2:0] FLD_DAY   = 3'd3;
  localparam logic [2:0] FLD_HOUR  = 3'd4;
  localparam logic [2:0] FLD_MIN   = 3'd5;
  localparam logic [2:0] FLD_SEC   = 3'd6;
  localparam logic [2:0] FLD_WEEK  = 3'd7;

  localparam logic [3:0] MON = 4'd1;
  localparam logic [3:0] TUE = 4'd2;
  localparam logic [3:0] WED = 4'd3;
  localparam logic [3:0] THU = 4'd4;
  localparam logic [3:0] FRI = 4'd5;
  localparam logic [3:0] SAT = 4'd6;
  localparam logic [3:0] SUN = 4'd7;

  // State value equals the field index shown on the display.
  typedef enum logic [2:0] {
    ST_RUN   = FLD_RUN,
    ST_YEAR  = FLD_YEAR,
    ST_MONTH = FLD_MONTH,
    ST_DAY   = FLD_DAY,
    ST_HOUR  = FLD_HOUR,
    ST_MIN   = FLD_MIN,
    ST_SEC   = FLD_SEC,
    ST_WEEK  = FLD_WEEK
  } state_t;

  function automatic logic is_leap(input logic [14:0] year);
    int y;
    y = int'(year);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] month, input logic [14:0] year);
    logic [4:0] len;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = is_leap(year) ? 5'd29 : 5'd28;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

  function automatic logic [3:0] zeller_to_iso(input int h);
    logic [3:0] w;
    case (h)
      0:       w = SAT;
      1:       w = SUN;
      2:       w = MON;
      3:       w = TUE;
      4:       w = WED;
      5:       w = THU;
      default: w = FRI;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/time_setter_if.sv
// time_setter_if: buttons, live timekeeper outputs and the timekeeper load bus.
//   btn_set/next/up/down : synchronised button levels
//   cur_*                : live time from the timekeeper (cur_week only when
//                          WEEKDAY_CALC_EN is undefined)
//   year_d..sec_d,week_s : load bus towards the timekeeper
//   mode                 : 0 = timekeeper loads the bus, 1 = timekeeper runs
//   field                : field under edit, 0 when running
// Modport master is the controller side; slave is the buttons/timekeeper side.
// Signals are plain levels with no valid/ready handshake: the bus is
// meaningful whenever mode == 0 and is ignored otherwise.
interface time_setter_if;
  logic        btn_set;
  logic        btn_next;
  logic        btn_up;
  logic        btn_down;
  logic [15:0] cur_year;
  logic [5:0]  cur_month;
  logic [10:0] cur_day;
  logic [10:0] cur_hour;
  logic [10:0] cur_min;
  logic [10:0] cur_sec;
`ifndef WEEKDAY_CALC_EN
  logic [10:0] cur_week;
`endif
  logic [14:0] year_d;
  logic [3:0]  month_d;
  logic [4:0]  day_d;
  logic [5:0]  hour_d;
  logic [5:0]  min_d;
  logic [5:0]  sec_d;
  logic [3:0]  week_s;
  logic [3:0]  mode;
  logic [2:0]  field;

  modport master (
`ifndef WEEKDAY_CALC_EN
    input  cur_week,
`endif
    input  btn_set, btn_next, btn_up, btn_down,
    input  cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
    output year_d, month_d, day_d, hour_d, min_d, sec_d, week_s, mode, field
  );

  modport slave (
`ifndef WEEKDAY_CALC_EN
    output cur_week,
`endif
    output btn_set, btn_next, btn_up, btn_down,
    output cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
    input  year_d, month_d, day_d, hour_d, min_d, sec_d, week_s, mode, field
  );
endinterface

// File: rtl/weekday_calc.sv
// weekday_calc: combinational weekday of a Gregorian date (Zeller's congruence).
//   year  in 15 : calendar year
//   month in 4  : 1..12
//   day   in 5  : 1..31
//   week  out 4 : 1 = Monday .. 7 = Sunday
// Only exists when WEEKDAY_CALC_EN is defined; otherwise the file is empty.
`ifdef WEEKDAY_CALC_EN
module weekday_calc
  import time_pkg::*;
(
  input  logic [14:0] year,
  input  logic [3:0]  month,
  input  logic [4:0]  day,
  output logic [3:0]  week
);
  int y;
  int m;
  int k;
  int j;
  int h;

  always_comb begin
    y = int'(year);
    m = int'(month);
    // January and February count as months 13/14 of the previous year.
    if (m < 3) begin
      m = m + 12;
      y = y - 1;
    end
    k = y % 100;
    j = y / 100;
    h = (int'(day) + (13 * (m + 1)) / 5 + k + k / 4 + j / 4 + 5 * j) % 7;
    week = zeller_to_iso(h);
  end
endmodule
`endif

// File: rtl/time_setter.sv
// time_setter: push-button edit session for the timekeeper's load bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : time_setter_if.master (buttons, live time in, load bus out)
// Set in RUN captures the live time and starts editing at the year field;
// next walks the fields, up/down change the current one with wrap-around,
// set again hands the edited time back by returning mode to 1.
// Build option WEEKDAY_CALC_EN: week_s follows the edited date (registered
// Zeller result). Without it week_s is captured at entry and edited by hand
// in an extra field after seconds.
module time_setter
  import time_pkg::*;
#(
  parameter int MIN_YEAR  = 2000,
  parameter int MAX_YEAR  = 2099,
  parameter int RST_YEAR  = 2023,
  parameter int RST_MONTH = 5,
  parameter int RST_DAY   = 9
) (
  input logic           clk,
  input logic           rst,
  time_setter_if.master bus
);
  localparam logic [14:0] MIN_Y = 15'(MIN_YEAR);
  localparam logic [14:0] MAX_Y = 15'(MAX_YEAR);
  localparam logic [14:0] RST_Y = 15'(RST_YEAR);
  localparam logic [3:0]  RST_M = 4'(RST_MONTH);
  localparam logic [4:0]  RST_D = 5'(RST_DAY);

  state_t      state_q, state_d;
  logic [14:0] year_q, year_n;
  logic [3:0]  month_q, month_n;
  logic [4:0]  day_q, day_n;
  logic [5:0]  hour_q, hour_n;
  logic [5:0]  min_q, min_n;
  logic [5:0]  sec_q, sec_n;
  logic [3:0]  week_q;
`ifndef WEEKDAY_CALC_EN
  logic [3:0]  week_n;
`endif

  logic [3:0]  btn_now, btn_q, pulse;
  logic        set_p, next_p, up_act, dn_act;
  logic [14:0] cap_year, step_year;
  logic [3:0]  cap_month, step_month;
  logic [4:0]  cap_day, cap_len, cur_len, year_len, mon_len;

  // Button order inside the history vector: set, next, up, down.
  assign btn_now = {bus.btn_set, bus.btn_next, bus.btn_up, bus.btn_down};
  assign pulse   = btn_now & ~btn_q;
  assign set_p   = pulse[3];
  assign next_p  = pulse[2];
  // Simultaneous up and down cancel each other.
  assign up_act  = pulse[1] & ~pulse[0];
  assign dn_act  = pulse[0] & ~pulse[1];

  always_comb begin
    state_d = state_q;
    year_n  = year_q;
    month_n = month_q;
    day_n   = day_q;
    hour_n  = hour_q;
    min_n   = min_q;
    sec_n   = sec_q;
`ifndef WEEKDAY_CALC_EN
    week_n  = week_q;
`endif

    // Sanitised capture of the live time.
    cap_year = bus.cur_year[14:0];
    if (cap_year < MIN_Y || cap_year > MAX_Y) cap_year = MIN_Y;
    cap_month = bus.cur_month[3:0];
    if (cap_month == 4'd0 || cap_month > 4'd12) cap_month = 4'd1;
    cap_len = month_len(cap_month, cap_year);
    cap_day = bus.cur_day[4:0];
    if (cap_day == 5'd0) cap_day = 5'd1;
    else if (cap_day > cap_len) cap_day = cap_len;

    // Candidate year/month after one step, and the month lengths they imply
    // so the day can be pulled back in the same update.
    if (up_act) begin
      step_year  = (year_q >= MAX_Y) ? MIN_Y : year_q + 15'd1;
      step_month = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
    end else begin
      step_year  = (year_q <= MIN_Y) ? MAX_Y : year_q - 15'd1;
      step_month = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
    end
    cur_len  = month_len(month_q, year_q);
    year_len = month_len(month_q, step_year);
    mon_len  = month_len(step_month, year_q);

    if (state_q == ST_RUN) begin
      if (set_p) begin
        year_n  = cap_year;
        month_n = cap_month;
        day_n   = cap_day;
        hour_n  = bus.cur_hour[5:0];
        min_n   = bus.cur_min[5:0];
        sec_n   = bus.cur_sec[5:0];
`ifndef WEEKDAY_CALC_EN
        week_n  = bus.cur_week[3:0];
`endif
        state_d = ST_YEAR;
      end
    end else if (set_p) begin
      state_d = ST_RUN;
    end else if (next_p) begin
      case (state_q)
        ST_YEAR:  state_d = ST_MONTH;
        ST_MONTH: state_d = ST_DAY;
        ST_DAY:   state_d = ST_HOUR;
        ST_HOUR:  state_d = ST_MIN;
        ST_MIN:   state_d = ST_SEC;
`ifdef WEEKDAY_CALC_EN
        ST_SEC:   state_d = ST_YEAR;
`else
        ST_SEC:   state_d = ST_WEEK;
`endif
        default:  state_d = ST_YEAR;
      endcase
    end else if (up_act || dn_act) begin
      case (state_q)
        ST_YEAR: begin
          year_n = step_year;
          if (day_q > year_len) day_n = year_len;
        end
        ST_MONTH: begin
          month_n = step_month;
          if (day_q > mon_len) day_n = mon_len;
        end
        ST_DAY:
          if (up_act) day_n = (day_q >= cur_len) ? 5'd1 : day_q + 5'd1;
          else        day_n = (day_q <= 5'd1) ? cur_len : day_q - 5'd1;
        ST_HOUR:
          if (up_act) hour_n = (hour_q >= 6'd23) ? 6'd0 : hour_q + 6'd1;
          else        hour_n = (hour_q == 6'd0) ? 6'd23 : hour_q - 6'd1;
        ST_MIN:
          if (up_act) min_n = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
          else        min_n = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        ST_SEC:
          if (up_act) sec_n = (sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1;
          else        sec_n = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
`ifndef WEEKDAY_CALC_EN
        ST_WEEK:
          if (up_act) week_n = (week_q >= SUN) ? MON : week_q + 4'd1;
          else        week_n = (week_q <= MON) ? SUN : week_q - 4'd1;
`endif
        default: ;
      endcase
    end
  end

`ifdef WEEKDAY_CALC_EN
  logic [3:0] week_calc;

  weekday_calc u_weekday (
    .year  (year_q),
    .month (month_q),
    .day   (day_q),
    .week  (week_calc)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      year_q  <= RST_Y;
      month_q <= RST_M;
      day_q   <= RST_D;
      hour_q  <= 6'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      week_q  <= TUE;
      btn_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      year_q  <= year_n;
      month_q <= month_n;
      day_q   <= day_n;
      hour_q  <= hour_n;
      min_q   <= min_n;
      sec_q   <= sec_n;
`ifdef WEEKDAY_CALC_EN
      // Follows the registered date, so it settles one cycle after an edit.
      week_q  <= week_calc;
`else
      week_q  <= week_n;
`endif
      btn_q   <= btn_now;
    end
  end

  assign bus.year_d  = year_q;
  assign bus.month_d = month_q;
  assign bus.day_d   = day_q;
  assign bus.hour_d  = hour_q;
  assign bus.min_d   = min_q;
  assign bus.sec_d   = sec_q;
  assign bus.week_s  = week_q;
  assign bus.field   = state_q;
  assign bus.mode    = (state_q == ST_RUN) ? 4'd1 : 4'd0;

  // High bits of the live inputs are dropped by design.
  logic unused_bits;
`ifdef WEEKDAY_CALC_EN
  assign unused_bits = ^{bus.cur_year[15], bus.cur_month[5:4], bus.cur_day[10:5],
                         bus.cur_hour[10:6], bus.cur_min[10:6], bus.cur_sec[10:6]};
`else
  assign unused_bits = ^{bus.cur_year[15], bus.cur_month[5:4], bus.cur_day[10:5],
                         bus.cur_hour[10:6], bus.cur_min[10:6], bus.cur_sec[10:6],
                         bus.cur_week[10:4]};
`endif

endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: randomized and directed stimulus against a calendar-level
// reference model of the time-setting controller.
module tb_time_setter;

  localparam int MIN_YEAR  = 2000;
  localparam int MAX_YEAR  = 2099;
  localparam int RST_YEAR  = 2023;
  localparam int RST_MONTH = 5;
  localparam int RST_DAY   = 9;

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_SET  = 4'b1000;
  localparam logic [3:0] B_NEXT = 4'b0100;
  localparam logic [3:0] B_UP   = 4'b0010;
  localparam logic [3:0] B_DOWN = 4'b0001;

`ifdef WEEKDAY_CALC_EN
  localparam int LAST_F = 6;
`else
  localparam int LAST_F = 7;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  time_setter_if bus ();

  time_setter #(
    .MIN_YEAR  (MIN_YEAR),
    .MAX_YEAR  (MAX_YEAR),
    .RST_YEAR  (RST_YEAR),
    .RST_MONTH (RST_MONTH),
    .RST_DAY   (RST_DAY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // ---------------- scoreboard ----------------
  int checks_n = 0;
  int fail_n   = 0;
  logic [52:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      fail_n++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_f, m_y, m_mo, m_d, m_h, m_mi, m_s, m_w;
  logic [3:0] m_prev;

  function automatic int leap(input int y);
    return (((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0)) ? 1 : 0;
  endfunction

  function automatic int mlen(input int m, input int y);
    int tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    return (m == 2) ? 28 + leap(y) : tab[m-1];
  endfunction

`ifdef WEEKDAY_CALC_EN
  // Counts days from 2000-01-01, which was a Saturday.
  function automatic int weekday_of(input int y, input int m, input int d);
    int days = 0;
    for (int yy = 2000; yy < y; yy++) days += 365 + leap(yy);
    for (int mm = 1; mm < m; mm++) days += mlen(mm, y);
    days += d - 1;
    return ((days + 5) % 7) + 1;
  endfunction
`endif

  task automatic model_step(input bit r, input logic [3:0] lv);
    logic [3:0] p;
    int dl;
    int ml;
`ifdef WEEKDAY_CALC_EN
    int wk_next;
    wk_next = weekday_of(m_y, m_mo, m_d);
`endif
    p = lv & ~m_prev;
    if (r) begin
      m_f = 0; m_y = RST_YEAR; m_mo = RST_MONTH; m_d = RST_DAY;
      m_h = 0; m_mi = 0; m_s = 0; m_w = 2; m_prev = 4'd0;
    end else begin
      m_prev = lv;
      dl = (p[1] && !p[0]) ? 1 : ((p[0] && !p[1]) ? -1 : 0);
      if (m_f == 0) begin
        if (p[3]) begin
          m_y = int'(bus.cur_year) % 32768;
          if (m_y < MIN_YEAR || m_y > MAX_YEAR) m_y = MIN_YEAR;
          m_mo = int'(bus.cur_month) % 16;
          if (m_mo == 0 || m_mo > 12) m_mo = 1;
          m_d = int'(bus.cur_day) % 32;
          if (m_d < 1) m_d = 1;
          if (m_d > mlen(m_mo, m_y)) m_d = mlen(m_mo, m_y);
          m_h  = int'(bus.cur_hour) % 64;
          m_mi = int'(bus.cur_min) % 64;
          m_s  = int'(bus.cur_sec) % 64;
`ifndef WEEKDAY_CALC_EN
          m_w  = int'(bus.cur_week) % 16;
`endif
          m_f = 1;
        end
      end else if (p[3]) begin
        m_f = 0;
      end else if (p[2]) begin
        m_f = (m_f == LAST_F) ? 1 : m_f + 1;
      end else if (dl != 0) begin
        case (m_f)
          1: begin
            m_y = MIN_YEAR + ((m_y - MIN_YEAR + dl + 100) % 100);
            if (m_d > mlen(m_mo, m_y)) m_d = mlen(m_mo, m_y);
          end
          2: begin
            m_mo = ((m_mo - 1 + dl + 12) % 12) + 1;
            if (m_d > mlen(m_mo, m_y)) m_d = mlen(m_mo, m_y);
          end
          3: begin
            ml = mlen(m_mo, m_y);
            m_d = ((m_d - 1 + dl + ml) % ml) + 1;
          end
          4: m_h  = (m_h + dl + 24) % 24;
          5: m_mi = (m_mi + dl + 60) % 60;
          6: m_s  = (m_s + dl + 60) % 60;
          default: m_w = ((m_w - 1 + dl + 7) % 7) + 1;
        endcase
      end
`ifdef WEEKDAY_CALC_EN
      m_w = wk_next;
`endif
    end
    exp_q.push_back({15'(m_y), 4'(m_mo), 5'(m_d), 6'(m_h), 6'(m_mi), 6'(m_s),
                     4'(m_w), ((m_f == 0) ? 4'd1 : 4'd0), 3'(m_f)});
  endtask

  task automatic check_all();
    logic [52:0] e;
    e = exp_q.pop_front();
    check_val("year",  32'(bus.year_d),  32'(e[52:38]));
    check_val("month", 32'(bus.month_d), 32'(e[37:34]));
    check_val("day",   32'(bus.day_d),   32'(e[33:29]));
    check_val("hour",  32'(bus.hour_d),  32'(e[28:23]));
    check_val("min",   32'(bus.min_d),   32'(e[22:17]));
    check_val("sec",   32'(bus.sec_d),   32'(e[16:11]));
    check_val("week",  32'(bus.week_s),  32'(e[10:7]));
    check_val("mode",  32'(bus.mode),    32'(e[6:3]));
    check_val("field", 32'(bus.field),   32'(e[2:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input bit r, input logic [3:0] b);
    @(negedge clk);
    rst          = r;
    bus.btn_set  = b[3];
    bus.btn_next = b[2];
    bus.btn_up   = b[1];
    bus.btn_down = b[0];
    @(posedge clk);
    model_step(r, b);
    #1;
    check_all();
  endtask

  task automatic press(input logic [3:0] b);
    tick(1'b0, b);
    tick(1'b0, B_NONE);
  endtask

  task automatic set_cur(input int y, input int mo, input int d, input int h,
                         input int mi, input int s, input int w);
    bus.cur_year  = 16'(y);
    bus.cur_month = 6'(mo);
    bus.cur_day   = 11'(d);
    bus.cur_hour  = 11'(h);
    bus.cur_min   = 11'(mi);
    bus.cur_sec   = 11'(s);
`ifndef WEEKDAY_CALC_EN
    bus.cur_week  = 11'(w);
`else
    if (w < 0) $display("note: negative weekday ignored");
`endif
  endtask

  // Commits any open session, then opens a new one from the given live time.
  task automatic enter(input int y, input int mo, input int d, input int h,
                       input int mi, input int s, input int w);
    if (m_f != 0) press(B_SET);
    set_cur(y, mo, d, h, mi, s, w);
    press(B_SET);
  endtask

  task automatic goto_field(input int f);
    for (int i = 0; i < 8 && m_f != f; i++) press(B_NEXT);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] lv;
    bus.btn_set = 1'b0; bus.btn_next = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    set_cur(2023, 5, 9, 11, 59, 58, 2);
    m_prev = 4'd0;

    tick(1'b1, B_NONE);
    tick(1'b1, B_NONE);
    check_val("rst_mode",  32'(bus.mode), 1);
    check_val("rst_field", 32'(bus.field), 0);
    check_val("rst_year",  32'(bus.year_d), 2023);
    check_val("rst_week",  32'(bus.week_s), 2);

    // Entry captures the live time one cycle after set rises.
    tick(1'b0, B_SET);
    check_val("entry_mode",  32'(bus.mode), 0);
    check_val("entry_field", 32'(bus.field), 1);
    check_val("entry_day",   32'(bus.day_d), 9);
    check_val("entry_sec",   32'(bus.sec_d), 58);
    check_val("entry_week",  32'(bus.week_s), 2);
    tick(1'b0, B_NONE);

    enter(2024, 2, 28, 10, 0, 0, 3);
    goto_field(3);
    press(B_UP);
    check_val("leap_day29", 32'(bus.day_d), 29);
    press(B_UP);
    check_val("leap_wrap1", 32'(bus.day_d), 1);

    enter(2023, 2, 27, 10, 0, 0, 1);
    goto_field(3);
    press(B_UP);
    check_val("feb_day28", 32'(bus.day_d), 28);
    press(B_UP);
    check_val("feb_wrap1", 32'(bus.day_d), 1);

    enter(2024, 2, 29, 1, 2, 3, 4);
    press(B_DOWN);
    check_val("yr_down_year", 32'(bus.year_d), 2023);
    check_val("yr_down_clamp", 32'(bus.day_d), 28);

    enter(2000, 2, 29, 1, 2, 3, 2);
    check_val("y2000_leap", 32'(bus.day_d), 29);

    enter(2099, 6, 15, 0, 30, 30, 1);
    press(B_UP);
    check_val("year_wrap", 32'(bus.year_d), 2000);
    goto_field(4);
    press(B_DOWN);
    check_val("hour_wrap", 32'(bus.hour_d), 23);
    press(B_UP | B_DOWN);
    check_val("up_down_cancel", 32'(bus.hour_d), 23);
    for (int i = 0; i < 100; i++) tick(1'b0, B_UP);
    tick(1'b0, B_NONE);
    check_val("hold_single", 32'(bus.hour_d), 0);

    enter(2024, 3, 31, 5, 5, 5, 7);
    goto_field(2);
    press(B_DOWN);
    check_val("mon_clamp_m", 32'(bus.month_d), 2);
    check_val("mon_clamp_d", 32'(bus.day_d), 29);

`ifndef WEEKDAY_CALC_EN
    enter(2024, 3, 31, 5, 5, 5, 1);
    goto_field(7);
    check_val("week_field", 32'(bus.field), 7);
    press(B_DOWN);
    check_val("week_wrap_dn", 32'(bus.week_s), 7);
    press(B_UP);
    check_val("week_wrap_up", 32'(bus.week_s), 1);
    press(B_NEXT);
    check_val("week_next", 32'(bus.field), 1);
`else
    enter(2024, 1, 2, 0, 0, 0, 0);
    goto_field(3);
    tick(1'b0, B_DOWN);
    check_val("wd_lag_old", 32'(bus.week_s), 2);
    tick(1'b0, B_NONE);
    check_val("wd_2024_01_01", 32'(bus.week_s), 1);
    enter(2000, 2, 28, 0, 0, 0, 0);
    goto_field(3);
    press(B_UP);
    tick(1'b0, B_NONE);
    check_val("wd_2000_02_29", 32'(bus.week_s), 2);
`endif

    // Reset during an edit aborts the session.
    enter(2031, 8, 20, 7, 45, 12, 3);
    goto_field(5);
    tick(1'b1, B_NONE);
    check_val("abort_mode",  32'(bus.mode), 1);
    check_val("abort_field", 32'(bus.field), 0);
    check_val("abort_year",  32'(bus.year_d), 2023);
    check_val("abort_min",   32'(bus.min_d), 0);
    tick(1'b0, B_NONE);
    set_cur(2045, 11, 30, 22, 10, 5, 6);
    press(B_SET);
    check_val("recapture_year", 32'(bus.year_d), 2045);

    // Random phase: sticky button levels, random live time, rare resets.
    lv = 4'd0;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) lv[b] = ~lv[b];
      if ($urandom_range(0, 3) == 0)
        set_cur($urandom_range(0, 19) == 0 ? int'($urandom_range(0, 65535)) : int'($urandom_range(1990, 2110)),
                $urandom_range(0, 15), $urandom_range(0, 40), $urandom_range(0, 23),
                $urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(1, 7));
      tick(($urandom_range(0, 199) == 0), lv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
    $finish;
  end

endmodule
